// File: rtl/lane_reset_sequencer_if.sv
// Control/status bundle between a lane reset sequencer and its lane logic.
// The sequencer takes the slave view: it consumes en/cdr_lock and drives the
// datapath resets, status flags and debug state.
interface lane_reset_sequencer_if;
  logic       en;
  logic       cdr_lock;
  logic       tx_rst;
  logic       rx_rst;
  logic       ready;
  logic       timeout_err;
  logic [2:0] state;

  modport master (
    output en, cdr_lock,
    input  tx_rst, rx_rst, ready, timeout_err, state
  );

  modport slave (
    input  en, cdr_lock,
    output tx_rst, rx_rst, ready, timeout_err, state
  );
endinterface

// File: rtl/lane_reset_sequencer.sv
// Per-lane SerDes reset sequencer: holds TX in reset for a fixed time, then
// qualifies CDR lock for a stable interval (with timeout) before releasing RX.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | lane disabled, TX and RX held in reset
// TX_HOLD   | TX reset held for HOLD_CYCLES after enable
// WAIT_LOCK | TX running, counting consecutive cdr_lock cycles
// READY     | lock qualified, RX released, lane up
// ERROR     | lock never qualified in time; sticky until en=0 or reset
module lane_reset_sequencer #(
  parameter int HOLD_CYCLES  = 16,
  parameter int LOCK_STABLE  = 8,
  parameter int LOCK_TIMEOUT = 256,
  parameter int CNT_W        = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  lane_reset_sequencer_if.slave       lane_io
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TX_HOLD   = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_READY     = 3'd3,
    S_ERROR     = 3'd4
  } state_e;

  localparam int MAX_CNT = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;

  // Refuse to elaborate with parameters that would let a counter wrap
  // before its terminal compare fires.
  if (HOLD_CYCLES < 1 || LOCK_STABLE < 1 || LOCK_TIMEOUT <= LOCK_STABLE ||
      (MAX_CNT - 1) >= (1 << CNT_W)) begin : g_param_chk
    $error("lane_reset_sequencer: illegal HOLD_CYCLES/LOCK_STABLE/LOCK_TIMEOUT/CNT_W");
  end

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic             tx_rst_q, tx_rst_d;
  logic             rx_rst_q, rx_rst_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;

  // Next-state, counter and output decode; outputs follow the next state so
  // they switch on the same edge as the transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;

    if (state_q != S_IDLE && !lane_io.en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      scnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d  = '0;
          scnt_d = '0;
          if (lane_io.en) state_d = S_TX_HOLD;
        end
        S_TX_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
            scnt_d  = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        S_WAIT_LOCK: begin
          cnt_d  = cnt_q + ONE;
          scnt_d = lane_io.cdr_lock ? scnt_q + ONE : '0;
          // Lock completion is checked first so it wins a tie with timeout.
          if (lane_io.cdr_lock && scnt_q == STABLE_LAST) begin
            state_d = S_READY;
            cnt_d   = '0;
            scnt_d  = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = S_ERROR;
            cnt_d   = '0;
            scnt_d  = '0;
          end
        end
        S_READY: begin
          cnt_d  = '0;
          scnt_d = '0;
          if (!lane_io.cdr_lock) state_d = S_WAIT_LOCK;
        end
        S_ERROR: begin
          cnt_d  = '0;
          scnt_d = '0;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          scnt_d  = '0;
        end
      endcase
    end

    tx_rst_d = (state_d == S_IDLE) || (state_d == S_TX_HOLD);
    rx_rst_d = (state_d != S_READY);
    ready_d  = (state_d == S_READY);
    err_d    = (state_d == S_ERROR);
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      scnt_q   <= '0;
      tx_rst_q <= 1'b1;
      rx_rst_q <= 1'b1;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      scnt_q   <= scnt_d;
      tx_rst_q <= tx_rst_d;
      rx_rst_q <= rx_rst_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  assign lane_io.tx_rst      = tx_rst_q;
  assign lane_io.rx_rst      = rx_rst_q;
  assign lane_io.ready       = ready_q;
  assign lane_io.timeout_err = err_q;
  assign lane_io.state       = state_q;

endmodule

// File: tb/tb_lane_reset_sequencer.sv
// Directed bench for lane_reset_sequencer with default parameters
// (HOLD 16, STABLE 8, TIMEOUT 256). Observed word: {state, tx, rx, ready, err}.
module tb_lane_reset_sequencer;

  localparam logic [6:0] IDLE_V = 7'b000_1_1_0_0;
  localparam logic [6:0] TXH_V  = 7'b001_1_1_0_0;
  localparam logic [6:0] WL_V   = 7'b010_0_1_0_0;
  localparam logic [6:0] RDY_V  = 7'b011_0_0_1_0;
  localparam logic [6:0] ERR_V  = 7'b100_0_1_0_1;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  logic [6:0] obs;

  lane_reset_sequencer_if lane ();

  lane_reset_sequencer dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .lane_io (lane)
  );

  always #5 clk = ~clk;

  assign obs = {lane.state, lane.tx_rst, lane.rx_rst, lane.ready, lane.timeout_err};

  // One rising edge, then settle to the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lane.en = 1'b1; lane.cdr_lock = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (obs !== IDLE_V) begin miscompares++; $display("FAIL reset_e%0d: got %b expected %b", i, obs, IDLE_V); end
    end
    rst_n = 1'b1;
    step();
    vectors++;
    if (obs !== TXH_V) begin miscompares++; $display("FAIL reset_release: got %b expected %b", obs, TXH_V); end
    lane.en = 1'b0;
    step();
    vectors++;
    if (obs !== IDLE_V) begin miscompares++; $display("FAIL reset_disable: got %b expected %b", obs, IDLE_V); end
  endtask

  task automatic test_nominal();
    logic [6:0] exp;
    lane.en = 1'b1; lane.cdr_lock = 1'b1;
    step();
    vectors++;
    if (obs !== TXH_V) begin miscompares++; $display("FAIL nominal_e0: got %b expected %b", obs, TXH_V); end
    for (int k = 1; k <= 24; k++) begin
      step();
      exp = (k < 16) ? TXH_V : (k < 24) ? WL_V : RDY_V;
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL nominal_e%0d: got %b expected %b", k, obs, exp); end
    end
  endtask

  task automatic test_lock_loss();
    logic [6:0] exp;
    lane.cdr_lock = 1'b0;
    step();
    vectors++;
    if (obs !== WL_V) begin miscompares++; $display("FAIL lockloss_drop: got %b expected %b", obs, WL_V); end
    lane.cdr_lock = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = (k < 8) ? WL_V : RDY_V;
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL lockloss_relock_e%0d: got %b expected %b", k, obs, exp); end
    end
    lane.en = 1'b0;
    step();
    vectors++;
    if (obs !== IDLE_V) begin miscompares++; $display("FAIL lockloss_disable: got %b expected %b", obs, IDLE_V); end
  endtask

  task automatic test_glitch();
    logic [6:0] exp;
    lane.en = 1'b1; lane.cdr_lock = 1'b0;
    for (int k = 0; k <= 16; k++) step();
    vectors++;
    if (obs !== WL_V) begin miscompares++; $display("FAIL glitch_enter: got %b expected %b", obs, WL_V); end
    lane.cdr_lock = 1'b1;
    for (int k = 0; k < 5; k++) step();
    lane.cdr_lock = 1'b0;
    step();
    vectors++;
    if (obs !== WL_V) begin miscompares++; $display("FAIL glitch_low: got %b expected %b", obs, WL_V); end
    lane.cdr_lock = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = (k < 8) ? WL_V : RDY_V;
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL glitch_rerise_e%0d: got %b expected %b", k, obs, exp); end
    end
    lane.en = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    lane.en = 1'b1; lane.cdr_lock = 1'b0;
    for (int k = 0; k <= 16; k++) step();
    for (int k = 1; k <= 255; k++) step();
    vectors++;
    if (obs !== WL_V) begin miscompares++; $display("FAIL timeout_e255: got %b expected %b", obs, WL_V); end
    step();
    vectors++;
    if (obs !== ERR_V) begin miscompares++; $display("FAIL timeout_e256: got %b expected %b", obs, ERR_V); end
    for (int k = 0; k < 12; k++) begin
      lane.cdr_lock = (k % 2 == 0);
      step();
    end
    vectors++;
    if (obs !== ERR_V) begin miscompares++; $display("FAIL timeout_sticky: got %b expected %b", obs, ERR_V); end
    lane.en = 1'b0;
    step();
    vectors++;
    if (obs !== IDLE_V) begin miscompares++; $display("FAIL timeout_disable: got %b expected %b", obs, IDLE_V); end
  endtask

  task automatic test_prio_en();
    lane.en = 1'b1; lane.cdr_lock = 1'b1;
    for (int k = 0; k <= 16; k++) step();
    for (int k = 1; k <= 7; k++) step();
    vectors++;
    if (obs !== WL_V) begin miscompares++; $display("FAIL prio_en_pre: got %b expected %b", obs, WL_V); end
    lane.en = 1'b0;
    step();
    vectors++;
    if (obs !== IDLE_V) begin miscompares++; $display("FAIL prio_en_vs_lock: got %b expected %b", obs, IDLE_V); end
  endtask

  task automatic test_prio_rst();
    lane.en = 1'b1; lane.cdr_lock = 1'b0;
    for (int k = 0; k < 6; k++) step();
    vectors++;
    if (obs !== TXH_V) begin miscompares++; $display("FAIL prio_rst_pre: got %b expected %b", obs, TXH_V); end
    rst_n = 1'b0;
    step();
    vectors++;
    if (obs !== IDLE_V) begin miscompares++; $display("FAIL prio_rst_mid_hold: got %b expected %b", obs, IDLE_V); end
    rst_n = 1'b1; lane.en = 1'b0;
    step();
  endtask

  // Lock first sampled at WAIT_LOCK edge rise_edge; 249 ties with timeout.
  task automatic test_coincident(input int rise_edge, input logic [6:0] exp_end);
    lane.en = 1'b1; lane.cdr_lock = 1'b0;
    for (int k = 0; k <= 16; k++) step();
    for (int k = 1; k <= 255; k++) begin
      lane.cdr_lock = (k >= rise_edge);
      step();
    end
    vectors++;
    if (obs !== WL_V) begin miscompares++; $display("FAIL coinc_r%0d_e255: got %b expected %b", rise_edge, obs, WL_V); end
    step();
    vectors++;
    if (obs !== exp_end) begin miscompares++; $display("FAIL coinc_r%0d_e256: got %b expected %b", rise_edge, obs, exp_end); end
    lane.en = 1'b0;
    step();
    vectors++;
    if (obs !== IDLE_V) begin miscompares++; $display("FAIL coinc_r%0d_disable: got %b expected %b", rise_edge, obs, IDLE_V); end
  endtask

  initial begin
    rst_n = 1'b0; lane.en = 1'b0; lane.cdr_lock = 1'b0;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_lock_loss();
    test_glitch();
    test_timeout();
    test_prio_en();
    test_prio_rst();
    test_coincident(249, RDY_V);
    test_coincident(250, ERR_V);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
